// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run/halt controller: state encoding and PC width.
// Latency: none (types and constants only).
// Backpressure: none.
package cpu_run_ctrl_pkg;

    localparam int RC_PC_W = 32;

    // RC_STEP is only reachable when single-step support is compiled in.
    typedef enum logic [1:0] {
        RC_RUN    = 2'd0,
        RC_HALTED = 2'd1,
        RC_RESUME = 2'd2,
        RC_STEP   = 2'd3
    } rc_state_t;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control bundle between the pipeline/debug logic and the run/halt controller.
// Latency: none (wires only).
// Backpressure: none; pipe_stall is the controller's only hold signal toward the pipeline.
interface cpu_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic                 i_continue_sig;
    logic                 i_halt_req;
    logic [31:0]          i_halt_pc_in;
    logic                 i_step_mode;
    logic                 o_pipe_stall;
    logic                 o_wb_bubble;
    logic                 o_halted;
    logic [31:0]          o_halt_pc;
    logic [CNT_W-1:0]     o_cycle_cnt;
    logic [CNT_W-1:0]     o_halt_cnt;

    modport master (
        output i_continue_sig, i_halt_req, i_halt_pc_in, i_step_mode,
        input  o_pipe_stall, o_wb_bubble, o_halted, o_halt_pc, o_cycle_cnt, o_halt_cnt
    );

    modport slave (
        input  i_continue_sig, i_halt_req, i_halt_pc_in, i_step_mode,
        output o_pipe_stall, o_wb_bubble, o_halted, o_halt_pc, o_cycle_cnt, o_halt_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl_cont_sync_edge.sv
// Synchronises the asynchronous continue button and emits a 1-cycle pulse on its rising edge.
// Latency: SYNC_STAGES cycles from input change to pulse.
// Backpressure: none; a pulse nobody consumes is simply lost.
module cpu_run_ctrl_cont_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the async level through the synchroniser and keep last synced value for edge detect.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt controller: freezes IF..MEM on a retired halt instruction until a continue press; optional single-step under RUN_CTRL_STEP_EN.
// Latency: pipe_stall same cycle as halt_req; continue edge to RESUME (first advance) is SYNC_STAGES+1 cycles.
// Backpressure: pipe_stall holds every pipeline register and the PC; RESUME flushes the halt instr from WB.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    cpu_run_ctrl_if.slave io_ctl
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    rc_state_t            r_state;
    rc_state_t            w_state_nxt;
    logic                 w_cont_rise;
    logic                 w_run_like;
    logic                 w_halt_take;
    logic                 w_step_force;
    logic                 w_pipe_stall;
    logic                 w_wb_bubble;
    logic                 w_halted;
    logic [RC_PC_W-1:0]   r_halt_pc;
    logic [CNT_W-1:0]     r_cycle_cnt;
    logic [CNT_W-1:0]     r_halt_cnt;

    cpu_run_ctrl_cont_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cont_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (io_ctl.i_continue_sig),
        .o_rise  (w_cont_rise)
    );

`ifdef RUN_CTRL_STEP_EN
    // The step cycle advances like RUN; with no real halt in it, the controller forces a halt at its end.
    assign w_run_like   = (r_state == RC_RUN) || (r_state == RC_STEP);
    assign w_step_force = (r_state == RC_STEP) && !io_ctl.i_halt_req;
`else
    logic w_unused_step;
    assign w_unused_step = io_ctl.i_step_mode;
    assign w_run_like    = (r_state == RC_RUN);
    assign w_step_force  = 1'b0;
`endif

    assign w_halt_take = w_run_like && io_ctl.i_halt_req;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= RC_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: halt wins over a coincident continue edge, and edges outside HALTED are dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RC_RUN:    if (io_ctl.i_halt_req) w_state_nxt = RC_HALTED;
            RC_HALTED: if (w_cont_rise)       w_state_nxt = RC_RESUME;
`ifdef RUN_CTRL_STEP_EN
            RC_RESUME: w_state_nxt = io_ctl.i_step_mode ? RC_STEP : RC_RUN;
            RC_STEP:   w_state_nxt = RC_HALTED;
`else
            RC_RESUME: w_state_nxt = RC_RUN;
`endif
            default:   w_state_nxt = RC_RUN;
        endcase
    end

    // Output decode: stall is combinational on halt_req so the halt instr commits while younger stages freeze.
    always_comb begin
        w_pipe_stall = 1'b0;
        w_wb_bubble  = 1'b0;
        w_halted     = 1'b0;
        if (w_run_like) begin
            w_pipe_stall = io_ctl.i_halt_req;
        end else if (r_state == RC_HALTED) begin
            w_pipe_stall = 1'b1;
            w_halted     = 1'b1;
        end else if (r_state == RC_RESUME) begin
            w_wb_bubble  = 1'b1;
        end
    end

    // Debug state: halted PC and saturating run-cycle / halt-entry counters.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_halt_pc   <= '0;
            r_cycle_cnt <= '0;
            r_halt_cnt  <= '0;
        end else begin
            if (w_run_like && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
            end
            if (w_halt_take && (r_halt_cnt != '1)) begin
                r_halt_cnt <= r_halt_cnt + CNT_ONE;
            end
            if (w_halt_take || w_step_force) begin
                r_halt_pc <= io_ctl.i_halt_pc_in;
            end
        end
    end

    assign io_ctl.o_pipe_stall = w_pipe_stall;
    assign io_ctl.o_wb_bubble  = w_wb_bubble;
    assign io_ctl.o_halted     = w_halted;
    assign io_ctl.o_halt_pc    = r_halt_pc;
    assign io_ctl.o_cycle_cnt  = r_cycle_cnt;
    assign io_ctl.o_halt_cnt   = r_halt_cnt;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl with 4-bit counters so saturation is reachable quickly.
// Status is observed as {pipe_stall, wb_bubble, halted}.
// Expected values are queued when stimulus is driven and popped when the DUT is sampled.
module tb_cpu_run_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.CNT_W(4)) u_if ();

    cpu_run_ctrl #(
        .SYNC_STAGES (2),
        .CNT_W       (4)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_ctl  (u_if.slave)
    );

    int          total = 0;
    int          bad   = 0;
    int          hc_model = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [2:0]  obs_st;
    bit          ok;

    assign obs_st = {u_if.o_pipe_stall, u_if.o_wb_bubble, u_if.o_halted};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        u_if.i_halt_req = 1'b0;
        u_if.i_continue_sig = 1'b0;
        u_if.i_step_mode = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
        hc_model = 0;
    endtask

    // Pulses continue for one clock, waits (bounded) for RESUME, then retires the halt instr from WB.
    task automatic release_halt(output bit done);
        done = 1'b0;
        u_if.i_continue_sig = 1'b1;
        tick();
        u_if.i_continue_sig = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (u_if.o_wb_bubble === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        u_if.i_halt_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        u_if.i_halt_req = 1'b0;
        u_if.i_continue_sig = 1'b0;
        u_if.i_step_mode = 1'b0;
        u_if.i_halt_pc_in = 32'hDEAD_BEEF;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        repeat (5) tick();
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL reset_status got=%b want=%b", obs_st, e[2:0]); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_cycle_cnt !== e[3:0]) begin bad++; $display("FAIL reset_cycle_cnt got=%0d want=%0d", u_if.o_cycle_cnt, e[3:0]); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_halt_cnt !== e[3:0]) begin bad++; $display("FAIL reset_halt_cnt got=%0d want=%0d", u_if.o_halt_cnt, e[3:0]); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_halt_pc !== e) begin bad++; $display("FAIL reset_halt_pc got=%h want=%h", u_if.o_halt_pc, e); end
        rst_n = 1'b1;
        hc_model = 0;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(32'(k));
            tick();
            e = exp_q.pop_front(); total++;
            if (u_if.o_cycle_cnt !== e[3:0]) begin bad++; $display("FAIL run_cycle_cnt got=%0d want=%0d", u_if.o_cycle_cnt, e[3:0]); end
            total++;
            if (obs_st !== 3'b000) begin bad++; $display("FAIL run_status got=%b want=000", obs_st); end
        end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (2) tick();
        u_if.i_halt_req = 1'b1;
        u_if.i_halt_pc_in = 32'h0000_0040;
        hc_model++;
        exp_q.push_back(32'b100);
        #1;
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL halt_same_cycle_stall got=%b want=%b", obs_st, e[2:0]); end
        exp_q.push_back(32'b101);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'(hc_model));
        exp_q.push_back(32'd3);
        tick();
        u_if.i_halt_pc_in = 32'h0000_0099;
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL halt_enter_status got=%b want=%b", obs_st, e[2:0]); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_halt_pc !== e) begin bad++; $display("FAIL halt_pc got=%h want=%h", u_if.o_halt_pc, e); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_halt_cnt !== e[3:0]) begin bad++; $display("FAIL halt_cnt got=%0d want=%0d", u_if.o_halt_cnt, e[3:0]); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_cycle_cnt !== e[3:0]) begin bad++; $display("FAIL halt_cycle_cnt got=%0d want=%0d", u_if.o_cycle_cnt, e[3:0]); end
        exp_q.push_back(32'h40);
        exp_q.push_back(32'd3);
        repeat (3) tick();
        e = exp_q.pop_front(); total++;
        if (u_if.o_halt_pc !== e) begin bad++; $display("FAIL halted_pc_frozen got=%h want=%h", u_if.o_halt_pc, e); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_cycle_cnt !== e[3:0]) begin bad++; $display("FAIL halted_cycle_frozen got=%0d want=%0d", u_if.o_cycle_cnt, e[3:0]); end
    endtask

    task automatic test_resume();
        // halt_req stays high: the frozen halt instr is still sitting in WB.
        u_if.i_continue_sig = 1'b1;
        exp_q.push_back(32'b101);
        exp_q.push_back(32'b101);
        exp_q.push_back(32'b010);
        exp_q.push_back(32'd3);
        tick();
        u_if.i_continue_sig = 1'b0;
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL resume_sync1 got=%b want=%b", obs_st, e[2:0]); end
        tick();
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL resume_sync2 got=%b want=%b", obs_st, e[2:0]); end
        tick();
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL resume_bubble got=%b want=%b", obs_st, e[2:0]); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_cycle_cnt !== e[3:0]) begin bad++; $display("FAIL resume_cycle_cnt got=%0d want=%0d", u_if.o_cycle_cnt, e[3:0]); end
        exp_q.push_back(32'b100);
        exp_q.push_back(32'b000);
        exp_q.push_back(32'b000);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'(hc_model));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL resume_to_run got=%b want=%b", obs_st, e[2:0]); end
        u_if.i_halt_req = 1'b0;
        #1;
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL run_after_resume got=%b want=%b", obs_st, e[2:0]); end
        tick();
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL no_rehalt got=%b want=%b", obs_st, e[2:0]); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_cycle_cnt !== e[3:0]) begin bad++; $display("FAIL post_resume_cycle_cnt got=%0d want=%0d", u_if.o_cycle_cnt, e[3:0]); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_halt_cnt !== e[3:0]) begin bad++; $display("FAIL post_resume_halt_cnt got=%0d want=%0d", u_if.o_halt_cnt, e[3:0]); end
    endtask

    task automatic test_cont_held();
        u_if.i_continue_sig = 1'b1;
        repeat (4) tick();
        u_if.i_halt_req = 1'b1;
        u_if.i_halt_pc_in = 32'h0000_0080;
        hc_model++;
        exp_q.push_back(32'h80);
        exp_q.push_back(32'(hc_model));
        tick();
        e = exp_q.pop_front(); total++;
        if (u_if.o_halt_pc !== e) begin bad++; $display("FAIL held_halt_pc got=%h want=%h", u_if.o_halt_pc, e); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_halt_cnt !== e[3:0]) begin bad++; $display("FAIL held_halt_cnt got=%0d want=%0d", u_if.o_halt_cnt, e[3:0]); end
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back(32'b101);
            tick();
            e = exp_q.pop_front(); total++;
            if (obs_st !== e[2:0]) begin bad++; $display("FAIL held_level_stays_halted cyc=%0d got=%b want=%b", i, obs_st, e[2:0]); end
        end
        u_if.i_continue_sig = 1'b0;
        repeat (3) tick();
        u_if.i_continue_sig = 1'b1;
        exp_q.push_back(32'b101);
        exp_q.push_back(32'b010);
        repeat (2) tick();
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL held_new_edge_sync got=%b want=%b", obs_st, e[2:0]); end
        tick();
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL held_new_edge_resume got=%b want=%b", obs_st, e[2:0]); end
        u_if.i_halt_req = 1'b0;
        u_if.i_continue_sig = 1'b0;
        exp_q.push_back(32'b000);
        tick();
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL held_back_to_run got=%b want=%b", obs_st, e[2:0]); end
    endtask

    task automatic test_coincide();
        repeat (3) tick();
        u_if.i_continue_sig = 1'b1;
        repeat (2) tick();
        // The synchronised rise is present during this cycle, together with the halt.
        u_if.i_halt_req = 1'b1;
        u_if.i_halt_pc_in = 32'h0000_00C0;
        hc_model++;
        exp_q.push_back(32'b101);
        exp_q.push_back(32'hC0);
        tick();
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL coincide_halt_wins got=%b want=%b", obs_st, e[2:0]); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_halt_pc !== e) begin bad++; $display("FAIL coincide_halt_pc got=%h want=%h", u_if.o_halt_pc, e); end
        exp_q.push_back(32'b101);
        repeat (5) tick();
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL coincide_edge_dropped got=%b want=%b", obs_st, e[2:0]); end
        u_if.i_continue_sig = 1'b0;
        repeat (3) tick();
        release_halt(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL coincide_release timeout got=%b want=1", ok); end
        exp_q.push_back(32'b000);
        tick();
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL coincide_run got=%b want=%b", obs_st, e[2:0]); end
    endtask

`ifdef RUN_CTRL_STEP_EN
    task automatic test_step();
        u_if.i_step_mode = 1'b1;
        u_if.i_halt_req = 1'b1;
        u_if.i_halt_pc_in = 32'h0000_0300;
        hc_model++;
        tick();
        for (int s = 0; s < 2; s++) begin
            release_halt(ok);
            total++;
            if (ok !== 1'b1) begin bad++; $display("FAIL step_release timeout got=%b want=1", ok); end
            exp_q.push_back(32'b000);
            tick();
            e = exp_q.pop_front(); total++;
            if (obs_st !== e[2:0]) begin bad++; $display("FAIL step_advance got=%b want=%b", obs_st, e[2:0]); end
            u_if.i_halt_pc_in = 32'h0000_0304 + 32'(s * 4);
            exp_q.push_back(32'b101);
            exp_q.push_back(32'h0000_0304 + 32'(s * 4));
            exp_q.push_back(32'(hc_model));
            tick();
            e = exp_q.pop_front(); total++;
            if (obs_st !== e[2:0]) begin bad++; $display("FAIL step_rehalt got=%b want=%b", obs_st, e[2:0]); end
            e = exp_q.pop_front(); total++;
            if (u_if.o_halt_pc !== e) begin bad++; $display("FAIL step_halt_pc got=%h want=%h", u_if.o_halt_pc, e); end
            e = exp_q.pop_front(); total++;
            if (u_if.o_halt_cnt !== e[3:0]) begin bad++; $display("FAIL step_halt_cnt got=%0d want=%0d", u_if.o_halt_cnt, e[3:0]); end
        end
        u_if.i_step_mode = 1'b0;
        release_halt(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL step_exit timeout got=%b want=1", ok); end
        exp_q.push_back(32'b000);
        repeat (3) tick();
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL step_off_runs got=%b want=%b", obs_st, e[2:0]); end
    endtask
`else
    task automatic test_step();
        u_if.i_step_mode = 1'b1;
        u_if.i_halt_req = 1'b1;
        u_if.i_halt_pc_in = 32'h0000_0300;
        hc_model++;
        tick();
        release_halt(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL step_ignored_release timeout got=%b want=1", ok); end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'b000);
            tick();
            e = exp_q.pop_front(); total++;
            if (obs_st !== e[2:0]) begin bad++; $display("FAIL step_ignored_run cyc=%0d got=%b want=%b", i, obs_st, e[2:0]); end
        end
        u_if.i_step_mode = 1'b0;
    endtask
`endif

    task automatic test_reset_halted();
        u_if.i_halt_req = 1'b1;
        u_if.i_halt_pc_in = 32'h0000_0200;
        tick();
        total++;
        if (obs_st !== 3'b101) begin bad++; $display("FAIL rst_pre_halted got=%b want=101", obs_st); end
        rst_n = 1'b0;
        u_if.i_halt_req = 1'b0;
        hc_model = 0;
        exp_q.push_back(32'b000);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        tick();
        e = exp_q.pop_front(); total++;
        if (obs_st !== e[2:0]) begin bad++; $display("FAIL rst_halted_status got=%b want=%b", obs_st, e[2:0]); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_cycle_cnt !== e[3:0]) begin bad++; $display("FAIL rst_halted_cycle_cnt got=%0d want=%0d", u_if.o_cycle_cnt, e[3:0]); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_halt_cnt !== e[3:0]) begin bad++; $display("FAIL rst_halted_halt_cnt got=%0d want=%0d", u_if.o_halt_cnt, e[3:0]); end
        e = exp_q.pop_front(); total++;
        if (u_if.o_halt_pc !== e) begin bad++; $display("FAIL rst_halted_pc got=%h want=%h", u_if.o_halt_pc, e); end
        rst_n = 1'b1;
        exp_q.push_back(32'd1);
        tick();
        e = exp_q.pop_front(); total++;
        if (u_if.o_cycle_cnt !== e[3:0]) begin bad++; $display("FAIL rst_release_cycle_cnt got=%0d want=%0d", u_if.o_cycle_cnt, e[3:0]); end
    endtask

    task automatic test_saturation();
        do_reset();
        exp_q.push_back(32'd15);
        repeat (20) tick();
        e = exp_q.pop_front(); total++;
        if (u_if.o_cycle_cnt !== e[3:0]) begin bad++; $display("FAIL cycle_cnt_saturate got=%0d want=%0d", u_if.o_cycle_cnt, e[3:0]); end
        for (int i = 0; i < 17; i++) begin
            u_if.i_halt_req = 1'b1;
            u_if.i_halt_pc_in = 32'h0000_1000 + 32'(i * 4);
            if (hc_model < 15) hc_model++;
            exp_q.push_back(32'h0000_1000 + 32'(i * 4));
            exp_q.push_back(32'(hc_model));
            tick();
            e = exp_q.pop_front(); total++;
            if (u_if.o_halt_pc !== e) begin bad++; $display("FAIL sat_halt_pc n=%0d got=%h want=%h", i, u_if.o_halt_pc, e); end
            e = exp_q.pop_front(); total++;
            if (u_if.o_halt_cnt !== e[3:0]) begin bad++; $display("FAIL sat_halt_cnt n=%0d got=%0d want=%0d", i, u_if.o_halt_cnt, e[3:0]); end
            release_halt(ok);
            total++;
            if (ok !== 1'b1) begin bad++; $display("FAIL sat_release timeout n=%0d got=%b want=1", i, ok); end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        u_if.i_continue_sig = 1'b0;
        u_if.i_halt_req = 1'b0;
        u_if.i_halt_pc_in = 32'h0;
        u_if.i_step_mode = 1'b0;
        test_reset();
        test_halt();
        test_resume();
        test_cont_held();
        test_coincide();
        test_step();
        test_reset_halted();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
